pixel_prefetch_fifo: RTL and testbench
======================================

PIXEL_PREFETCH_FIFO -- requirements
Module: pixel_prefetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter PRIME_LEVEL, default 8, fill level required before streaming starts; range 1..DEPTH.
REQ-003 SHALL have port clk, input, 1 bit, clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit, end-of-frame flush; synchronous.
REQ-006 SHALL have port dec_valid, input, 1 bit, decoder color valid.
REQ-007 SHALL have port dec_color, input, 32 bits, decoder pixel color.
REQ-008 SHALL have port dec_ready, output, 1 bit, FIFO accepts a color this cycle.
REQ-009 SHALL have port disp_read, input, 1 bit, display consumes one pixel (next_display_active).
REQ-010 SHALL have port disp_color, output, 32 bits, pixel presented to the display.
REQ-011 SHALL have port primed, output, 1 bit, FSM in RUN state.
REQ-012 SHALL have port level, output, $clog2(DEPTH+1) bits, current occupancy.
REQ-013 SHALL have port underflow, output, 1 bit, sticky; a read was missed since the last flush.

Function
REQ-014 SHALL push dec_color when dec_valid && dec_ready; dec_ready SHALL equal (level != DEPTH) && !flush.
REQ-015 SHALL be first-word-fall-through: disp_color SHALL equal the head entry combinationally when level > 0, otherwise UNDERFLOW_COLOR.
REQ-016 SHALL make a color pushed in cycle N visible on disp_color in cycle N+1 when the FIFO was empty.
REQ-017 SHALL have FSM states PRIME and RUN; PRIME->RUN when level >= PRIME_LEVEL; RUN->PRIME only on flush.
REQ-018 SHALL pop only when disp_read && state==RUN && level > 0.
REQ-019 SHALL set underflow when disp_read occurs while state==PRIME or level==0, and SHALL NOT pop in that case.
REQ-020 SHALL handle simultaneous push and pop: level unchanged, pointers each advance by one.
REQ-021 SHALL handle full with disp_read: pop occurs, no push that cycle (dec_ready=0), and level drops by 1.
REQ-022 SHALL handle empty with dec_valid and disp_read: push accepted, underflow set, level becomes 1.
REQ-023 SHALL wrap the pointers modulo DEPTH; the pointers are log2(DEPTH) bits and level is tracked separately.
REQ-024 SHALL give flush priority over push and pop: pointers=0, level=0, underflow=0, state=PRIME, all in the next cycle.

Reset
REQ-025 SHALL, while rst_n=0, force state=PRIME, pointers=0, level=0, underflow=0, dec_ready=0, primed=0, disp_color=UNDERFLOW_COLOR.
REQ-026 SHALL discard stored data on reset mid-frame; storage contents need no clearing.
REQ-027 SHALL let rst_n take priority over flush.

Configuration
REQ-028 SHALL, with PIXEL_FIFO_STATS_EN defined, add output underflow_cnt (16 bits, saturating count of missed reads) and output max_level (peak level); both SHALL clear on reset and on flush.
REQ-029 SHALL, without PIXEL_FIFO_STATS_EN, omit those ports entirely and leave all other behaviour identical.

Structure
REQ-030 SHALL take the following from shared package display_pkg: color_t (32-bit), UNDERFLOW_COLOR = 32'h00FF00FF, and the fifo_state_t enum {PRIME, RUN}.
REQ-031 SHALL place storage in sub-module pixel_fifo_mem (DEPTH x 32, one synchronous write port, one asynchronous read port); pointers, level and FSM stay in the top module.

Verification
REQ-032 SHALL cover the prime test: after reset, push 8 colors 0x01..0x08 with no reads -> primed rises the cycle after level reaches 8, and disp_color=0x01.
REQ-033 SHALL cover the streaming order test: push 0x10..0x2F while disp_read runs continuously once primed -> disp_color sequence is 0x10..0x2F, underflow=0, and pointer wrap is exercised.
REQ-034 SHALL cover the full test: push 16 colors with no reads -> dec_ready=0 and level=16; one disp_read -> level=15, and dec_ready=1 the next cycle.
REQ-035 SHALL cover the underflow test: assert disp_read during PRIME -> disp_color=0x00FF00FF, underflow=1, level unchanged; with PIXEL_FIFO_STATS_EN defined, underflow_cnt=1.
REQ-036 SHALL cover the flush test: at level 5 in RUN, assert flush with dec_valid and disp_read -> next cycle level=0, state=PRIME, underflow=0, and no push or pop occurred.
REQ-037 SHALL cover the reset test: drop rst_n mid-stream at level 10 -> next cycle level=0, primed=0, dec_ready=0; after release, dec_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display types: pixel color, the color shown when the prefetch FIFO
// has nothing to give, and the prefetch FIFO's fill-state encoding.
package display_pkg;

  typedef logic [31:0] color_t;

  localparam color_t UNDERFLOW_COLOR = 32'h00FF00FF;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel FIFO storage: one synchronous write port and one asynchronous read
// port. Contents are never cleared; occupancy tracking lives in the owner.
module pixel_fifo_mem
  import display_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr,
  output color_t        rdata
);

  color_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_prefetch_fifo.sv
// First-word-fall-through pixel prefetch FIFO that holds the display off until
// PRIME_LEVEL colors are buffered. Define PIXEL_FIFO_STATS_EN for the
// underflow_cnt / max_level statistics ports.
module pixel_prefetch_fifo
  import display_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       dec_valid,
  input  color_t                     dec_color,
  output logic                       dec_ready,
  input  logic                       disp_read,
  output color_t                     disp_color,
  output logic                       primed,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underflow
`ifdef PIXEL_FIFO_STATS_EN
  ,
  output logic [15:0]                underflow_cnt,
  output logic [$clog2(DEPTH+1)-1:0] max_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  fifo_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          underflow_q;
  logic          full, empty, push, pop, miss;
  color_t        rd_data;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign dec_ready = rst_n && !full && !flush;
  assign push      = dec_valid && dec_ready;
  // A read the FIFO cannot honour is recorded, never popped.
  assign miss      = disp_read && (state_q == PRIME || empty);
  assign pop       = disp_read && (state_q == RUN) && !empty && !flush;

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   if (level_q >= LW'(PRIME_LEVEL)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
    if (flush) state_d = PRIME;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PRIME;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_d;
      if (miss) underflow_q <= 1'b1;
    end
  end

  pixel_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (dec_color),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Outputs are forced to their idle values for as long as reset is held.
  assign disp_color = (rst_n && !empty) ? rd_data : UNDERFLOW_COLOR;
  assign primed     = rst_n && (state_q == RUN);
  assign level      = rst_n ? level_q : '0;
  assign underflow  = rst_n && underflow_q;

`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0]   ucnt_q;
  logic [LW-1:0] max_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ucnt_q <= '0;
      max_q  <= '0;
    end else begin
      if (miss && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 1'b1;
      if (level_d > max_q) max_q <= level_d;
    end
  end

  assign underflow_cnt = rst_n ? ucnt_q : '0;
  assign max_level     = rst_n ? max_q  : '0;
`endif

endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// Directed bench for pixel_prefetch_fifo: a per-cycle vector table followed by
// hand-written streaming, full, empty, flush and reset sequences.
module tb_pixel_prefetch_fifo;
  import display_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dec_valid = 1'b0;
  color_t      dec_color = '0;
  logic        dec_ready;
  logic        disp_read = 1'b0;
  color_t      disp_color;
  logic        primed;
  logic [4:0]  level;
  logic        underflow;
`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] underflow_cnt;
  logic [4:0]  max_level;
`endif

  always #5 clk = ~clk;

  pixel_prefetch_fifo #(
    .DEPTH       (16),
    .PRIME_LEVEL (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .dec_valid  (dec_valid),
    .dec_color  (dec_color),
    .dec_ready  (dec_ready),
    .disp_read  (disp_read),
    .disp_color (disp_color),
    .primed     (primed),
    .level      (level),
    .underflow  (underflow)
`ifdef PIXEL_FIFO_STATS_EN
    ,
    .underflow_cnt (underflow_cnt),
    .max_level     (max_level)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic       dec_valid;
    color_t     color;
    logic       disp_read;
    logic       e_ready;
    color_t     e_color;
    logic       e_primed;
    logic [4:0] e_level;
    logic       e_underflow;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic v, input color_t c,
                              input logic d, input logic er, input color_t ec, input logic ep,
                              input logic [4:0] el, input logic eu);
    vec_t t;
    t.rst_n = r; t.flush = f; t.dec_valid = v; t.color = c; t.disp_read = d;
    t.e_ready = er; t.e_color = ec; t.e_primed = ep; t.e_level = el; t.e_underflow = eu;
    return t;
  endfunction

  vec_t tbl [16];

  task automatic idle_inputs();
    flush = 1'b0; dec_valid = 1'b0; dec_color = '0; disp_read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pushed, reads, cyc;

    // Expected outputs are those seen with the row's inputs applied, before its clock edge.
    tbl[0] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, UNDERFLOW_COLOR, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(1'b1, 1'b0, 1'b1, color_t'(i), 1'b0, 1'b1,
                  (i == 1) ? UNDERFLOW_COLOR : 32'h1, 1'b0, 5'(i - 1), 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h1,  1'b0, 5'd8, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h1,  1'b1, 5'd8, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'hAA, 1'b1, 1'b0, 32'h1,  1'b1, 5'd8, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, UNDERFLOW_COLOR, 1'b0, 5'd0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1, UNDERFLOW_COLOR, 1'b0, 5'd0, 1'b1);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 1'b0, 5'd1, 1'b1);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h55, 1'b0, 5'd1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n     = tbl[i].rst_n;
      flush     = tbl[i].flush;
      dec_valid = tbl[i].dec_valid;
      dec_color = tbl[i].color;
      disp_read = tbl[i].disp_read;
      #1;
      chk($sformatf("v%0d_ready", i),     32'(dec_ready),  32'(tbl[i].e_ready));
      chk($sformatf("v%0d_color", i),     disp_color,      tbl[i].e_color);
      chk($sformatf("v%0d_primed", i),    32'(primed),     32'(tbl[i].e_primed));
      chk($sformatf("v%0d_level", i),     32'(level),      32'(tbl[i].e_level));
      chk($sformatf("v%0d_underflow", i), 32'(underflow),  32'(tbl[i].e_underflow));
`ifdef PIXEL_FIFO_STATS_EN
      if (i == 11) chk("v11_max_level", 32'(max_level), 32'd8);
      if (i == 12) chk("v12_max_level", 32'(max_level), 32'd0);
      if (i == 13) chk("v13_underflow_cnt", 32'(underflow_cnt), 32'd1);
`endif
    end

    // Streaming: 32 colors through a 16-deep FIFO, reading whenever primed.
    do_reset();
    pushed = 0; reads = 0; cyc = 0;
    while (reads < 32 && cyc < 200) begin
      dec_valid = (pushed < 32);
      dec_color = 32'h10 + pushed;
      disp_read = primed;
      #1;
      if (disp_read) begin
        chk("stream_order", disp_color, 32'h10 + reads);
        reads++;
      end
      if (dec_valid) pushed++;
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    #1;
    chk("stream_reads", 32'(reads), 32'd32);
    chk("stream_underflow", 32'(underflow), 32'd0);
    chk("stream_level", 32'(level), 32'd0);

    // Full, then one read: pop without push.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dec_valid = 1'b1; dec_color = 32'h100 + i;
      @(negedge clk);
    end
    dec_valid = 1'b0;
    #1;
    chk("full_ready", 32'(dec_ready), 32'd0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_head", disp_color, 32'h100);
    disp_read = 1'b1; dec_valid = 1'b1; dec_color = 32'hDEAD;
    #1;
    chk("full_read_ready", 32'(dec_ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("full_pop_level", 32'(level), 32'd15);
    chk("full_pop_ready", 32'(dec_ready), 32'd1);
    chk("full_pop_head", disp_color, 32'h101);

    // Empty with simultaneous push and read.
    do_reset();
    dec_valid = 1'b1; dec_color = 32'h77; disp_read = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("empty_level", 32'(level), 32'd1);
    chk("empty_underflow", 32'(underflow), 32'd1);
    chk("empty_color", disp_color, 32'h77);

    // Flush at level 5 in RUN with push and read requested.
    do_reset();
    disp_read = 1'b1;
    @(negedge clk);
    disp_read = 1'b0;
    #1;
    chk("flush_pre_underflow", 32'(underflow), 32'd1);
`ifdef PIXEL_FIFO_STATS_EN
    chk("flush_pre_cnt", 32'(underflow_cnt), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      dec_valid = 1'b1; dec_color = 32'h30 + i;
      @(negedge clk);
    end
    dec_valid = 1'b0;
    @(negedge clk);
    disp_read = 1'b1;
    repeat (3) @(negedge clk);
    disp_read = 1'b0;
    #1;
    chk("flush_pre_level", 32'(level), 32'd5);
    chk("flush_pre_primed", 32'(primed), 32'd1);
    chk("flush_pre_head", disp_color, 32'h33);
    flush = 1'b1; dec_valid = 1'b1; dec_color = 32'hBEEF; disp_read = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_primed", 32'(primed), 32'd0);
    chk("flush_underflow", 32'(underflow), 32'd0);
    chk("flush_color", disp_color, UNDERFLOW_COLOR);
`ifdef PIXEL_FIFO_STATS_EN
    chk("flush_cnt", 32'(underflow_cnt), 32'd0);
    chk("flush_max", 32'(max_level), 32'd0);
`endif
    @(negedge clk);
    #1;
    chk("flush_no_push", 32'(level), 32'd0);

    // Reset mid-stream at level 10.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dec_valid = 1'b1; dec_color = 32'h40 + i;
      @(negedge clk);
    end
    #1;
    chk("rst_pre_level", 32'(level), 32'd10);
    dec_color = 32'h99; disp_read = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_ready_low", 32'(dec_ready), 32'd0);
    chk("rst_primed_low", 32'(primed), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_ready", 32'(dec_ready), 32'd1);
    chk("rst_color", disp_color, UNDERFLOW_COLOR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
